// File: rtl/envelope_adsr_if.sv
// ---------------------------------------------------------------------------
// envelope_adsr_if
//   Sample-stream bundle for the ADSR envelope stage.
//
//   Inputs to the envelope (driven by the upstream side / master):
//     sample_en_i  one-cycle sample strobe
//     gate_i       key held (1) / released (0)
//     data_i       signed input sample, width_p bits
//   Outputs from the envelope (driven by the envelope / slave):
//     data_o       signed enveloped sample, width_p bits
//     valid_o      one-cycle pulse, data_o updated
//     env_o        current envelope level, env_width_p bits
//     state_o      IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
//     busy_o       state_o != IDLE
// ---------------------------------------------------------------------------
interface envelope_adsr_if #(
   parameter int width_p     = 24,
   parameter int env_width_p = 16
);
   logic                   sample_en_i;
   logic                   gate_i;
   logic [width_p-1:0]     data_i;
   logic [width_p-1:0]     data_o;
   logic                   valid_o;
   logic [env_width_p-1:0] env_o;
   logic [2:0]             state_o;
   logic                   busy_o;

   modport master (
      output sample_en_i, gate_i, data_i,
      input  data_o, valid_o, env_o, state_o, busy_o
   );

   modport slave (
      input  sample_en_i, gate_i, data_i,
      output data_o, valid_o, env_o, state_o, busy_o
   );
endinterface

// File: rtl/envelope_adsr.sv
// ---------------------------------------------------------------------------
// envelope_adsr
//   ADSR amplitude envelope placed after the waveform select mux. On every
//   sample strobe it advances an attack/decay/sustain/release state machine
//   and emits the input sample scaled by the envelope level held before that
//   strobe's update.
//
//   Ports:
//     clk_i            system clock (48 kHz sample clock in the top)
//     reset_ni         asynchronous, active-low reset
//     attack_rate_i    level increment per strobe in ATTACK (0 = instant)
//     decay_rate_i     level decrement per strobe in DECAY (0 = instant)
//     sustain_level_i  sustain level, sampled live
//     release_rate_i   level decrement per strobe in RELEASE (0 = instant)
//     bus              envelope_adsr_if.slave: strobe, gate, sample in;
//                      enveloped sample, valid, level, state, busy out
// ---------------------------------------------------------------------------
module envelope_adsr #(
   parameter int width_p     = 24,
   parameter int env_width_p = 16
) (
   input  logic                   clk_i,
   input  logic                   reset_ni,
   input  logic [env_width_p-1:0] attack_rate_i,
   input  logic [env_width_p-1:0] decay_rate_i,
   input  logic [env_width_p-1:0] sustain_level_i,
   input  logic [env_width_p-1:0] release_rate_i,
   envelope_adsr_if.slave         bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } state_e;

   localparam int prod_w_lp = width_p + env_width_p + 1;
   localparam logic [env_width_p-1:0] full_lp = {env_width_p{1'b1}};

   state_e                 state_r, state_n;
   logic [env_width_p-1:0] env_r, env_n;
   logic [width_p-1:0]     data_r;
   logic                   valid_r;

   // Attack sum carries one extra bit so overshoot past full scale is seen.
   logic [env_width_p:0]            attack_sum;
   // Decay difference is signed with headroom so env - rate never wraps.
   logic signed [env_width_p+1:0]   decay_diff;
   logic signed [prod_w_lp-1:0]     product;

   assign attack_sum = {1'b0, env_r} + {1'b0, attack_rate_i};
   assign decay_diff = $signed({2'b00, env_r}) - $signed({2'b00, decay_rate_i});

   // Zero-extend env so it multiplies as a non-negative signed fraction.
   assign product = prod_w_lp'($signed(bus.data_i))
                  * prod_w_lp'($signed({1'b0, env_r}));

   // -------------------------------------------------------------------
   // State / level / output registers
   // -------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_r <= IDLE;
         env_r   <= '0;
         data_r  <= '0;
         valid_r <= 1'b0;
      end else begin
         valid_r <= bus.sample_en_i;
         if (bus.sample_en_i) begin
            state_r <= state_n;
            env_r   <= env_n;
            // Arithmetic shift right by env_width_p, truncated to width_p.
            data_r  <= product[env_width_p +: width_p];
         end
      end
   end

   // -------------------------------------------------------------------
   // Next-state and next-level logic
   // -------------------------------------------------------------------
   // NOTE: defaults first so every path assigns state_n/env_n and no latch
   // is inferred.
   always_comb begin
      state_n = state_r;
      env_n   = env_r;
      unique case (state_r)
         IDLE: begin
            env_n = '0;
            if (bus.gate_i) state_n = ATTACK;
         end
         ATTACK: begin
            if (!bus.gate_i) begin
               state_n = RELEASE;
            end else if (attack_rate_i == '0 || attack_sum >= {1'b0, full_lp}) begin
               env_n   = full_lp;
               state_n = DECAY;
            end else begin
               env_n = attack_sum[env_width_p-1:0];
            end
         end
         DECAY: begin
            if (!bus.gate_i) begin
               state_n = RELEASE;
            end else if (decay_rate_i == '0
                         || decay_diff <= $signed({2'b00, sustain_level_i})) begin
               env_n   = sustain_level_i;
               state_n = SUSTAIN;
            end else begin
               env_n = decay_diff[env_width_p-1:0];
            end
         end
         SUSTAIN: begin
            if (!bus.gate_i) state_n = RELEASE;
            else             env_n   = sustain_level_i;
         end
         RELEASE: begin
            // Retrigger continues from the current level rather than zero.
            if (bus.gate_i) begin
               state_n = ATTACK;
            end else if (release_rate_i == '0 || env_r <= release_rate_i) begin
               env_n   = '0;
               state_n = IDLE;
            end else begin
               env_n = env_r - release_rate_i;
            end
         end
         default: begin
            env_n   = '0;
            state_n = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------
   always_comb begin
      bus.data_o  = data_r;
      bus.valid_o = valid_r;
      bus.env_o   = env_r;
      bus.state_o = state_r;
      bus.busy_o  = (state_r != IDLE);
   end

endmodule

// File: tb/tb_envelope_adsr.sv
// ---------------------------------------------------------------------------
// tb_envelope_adsr
//   Directed bench for envelope_adsr: reset, attack ramp, decay to sustain,
//   sustain tracking, scaling corner values, release, retrigger, async reset
//   mid-attack and sparse sample strobes. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_envelope_adsr;

   logic        clk_i = 1'b0;
   logic        reset_ni = 1'b0;
   logic [15:0] attack_rate_i = '0;
   logic [15:0] decay_rate_i = '0;
   logic [15:0] sustain_level_i = '0;
   logic [15:0] release_rate_i = '0;

   int n_vec = 0;
   int n_err = 0;

   envelope_adsr_if #(.width_p(24), .env_width_p(16)) bus ();

   envelope_adsr #(.width_p(24), .env_width_p(16)) dut (
      .clk_i           (clk_i),
      .reset_ni        (reset_ni),
      .attack_rate_i   (attack_rate_i),
      .decay_rate_i    (decay_rate_i),
      .sustain_level_i (sustain_level_i),
      .release_rate_i  (release_rate_i),
      .bus             (bus.slave)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock edge and settle 1 ns past it before sampling.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_env_state(input string tag, input logic [15:0] env, input logic [2:0] st);
      check({tag, " env"}, 32'(bus.env_o), 32'(env));
      check({tag, " state"}, 32'(bus.state_o), 32'(st));
   endtask

   initial begin
      logic [15:0] exp_env;
      logic [23:0] held_data;
      logic [23:0] strobe_data [3];
      logic [15:0] strobe_env [3];

      bus.sample_en_i = 1'b0;
      bus.gate_i      = 1'b0;
      bus.data_i      = '0;

      // ---- reset state ----
      #2;
      check("rst data", 32'(bus.data_o), 32'h0);
      check("rst env", 32'(bus.env_o), 32'h0);
      check("rst state", 32'(bus.state_o), 32'h0);
      check("rst valid", 32'(bus.valid_o), 32'h0);
      check("rst busy", 32'(bus.busy_o), 32'h0);
      step();
      reset_ni = 1'b1;

      // ---- attack ----
      attack_rate_i   = 16'h1000;
      decay_rate_i    = 16'h2000;
      sustain_level_i = 16'h8000;
      release_rate_i  = 16'h4000;
      bus.gate_i      = 1'b1;
      bus.sample_en_i = 1'b1;
      bus.data_i      = 24'h7FFFFF;
      step();
      check_env_state("atk enter", 16'h0000, 3'd1);
      check("atk enter valid", 32'(bus.valid_o), 32'h1);
      check("atk enter busy", 32'(bus.busy_o), 32'h1);
      check("atk enter data", 32'(bus.data_o), 32'h0);
      exp_env = 16'h0000;
      for (int i = 0; i < 15; i++) begin
         step();
         exp_env = exp_env + 16'h1000;
         check_env_state("atk ramp", exp_env, 3'd1);
      end
      step();
      check_env_state("atk top", 16'hFFFF, 3'd2);

      // ---- decay to sustain; first decay strobe scales by 0xFFFF ----
      step();
      check_env_state("dec 1", 16'hDFFF, 3'd2);
      check("scale ffff pos", 32'(bus.data_o), 32'h7FFF7F);
      step();
      check_env_state("dec 2", 16'hBFFF, 3'd2);
      step();
      check_env_state("dec 3", 16'h9FFF, 3'd2);
      step();
      check_env_state("dec sus", 16'h8000, 3'd3);

      // ---- sustain tracks its input ----
      sustain_level_i = 16'h6000;
      step();
      check_env_state("sus track", 16'h6000, 3'd3);
      sustain_level_i = 16'hFFFF;
      step();
      check_env_state("sus full", 16'hFFFF, 3'd3);

      // ---- scaling corners ----
      bus.data_i = 24'h7FFFFF;
      step();
      check("scale max pos", 32'(bus.data_o), 32'h7FFF7F);
      bus.data_i = 24'h800000;
      step();
      check("scale max neg", 32'(bus.data_o), 32'h800080);
      sustain_level_i = 16'h8000;
      step();
      check("sus back", 32'(bus.env_o), 32'h8000);
      bus.data_i = 24'hFFFFFD;   // -3
      step();
      check("scale floor", 32'(bus.data_o), 32'hFFFFFE);

      // ---- release to idle ----
      bus.gate_i = 1'b0;
      step();
      check_env_state("rel enter", 16'h8000, 3'd4);
      step();
      check_env_state("rel 1", 16'h4000, 3'd4);
      bus.data_i = 24'h123456;
      step();
      check_env_state("rel idle", 16'h0000, 3'd0);
      check("rel busy", 32'(bus.busy_o), 32'h0);
      step();
      check("scale zero", 32'(bus.data_o), 32'h0);

      // ---- retrigger from release ----
      attack_rate_i = 16'h4000;
      bus.gate_i    = 1'b1;
      step();
      check_env_state("rtg atk", 16'h0000, 3'd1);
      step();
      check_env_state("rtg ramp", 16'h4000, 3'd1);
      bus.gate_i = 1'b0;
      step();
      check_env_state("rtg rel", 16'h4000, 3'd4);
      bus.gate_i = 1'b1;
      step();
      check_env_state("rtg again", 16'h4000, 3'd1);
      step();
      check_env_state("rtg cont", 16'h8000, 3'd1);

      // ---- asynchronous reset mid-attack ----
      bus.data_i = 24'h7FFFFF;
      step();
      check("pre-rst data nz", 32'(bus.data_o != 24'h0), 32'h1);
      #2;
      reset_ni = 1'b0;
      #1;
      check("arst data", 32'(bus.data_o), 32'h0);
      check("arst env", 32'(bus.env_o), 32'h0);
      check("arst state", 32'(bus.state_o), 32'h0);
      check("arst valid", 32'(bus.valid_o), 32'h0);
      check("arst busy", 32'(bus.busy_o), 32'h0);
      step();
      reset_ni = 1'b1;

      // ---- sparse strobes: one every 4th cycle ----
      attack_rate_i   = 16'h1000;
      bus.gate_i      = 1'b1;
      strobe_env[0]   = 16'h0000;  strobe_data[0] = 24'h000000;
      strobe_env[1]   = 16'h1000;  strobe_data[1] = 24'h000000;
      strobe_env[2]   = 16'h2000;  strobe_data[2] = 24'h040000;
      for (int s = 0; s < 3; s++) begin
         bus.data_i      = 24'h400000;
         bus.sample_en_i = 1'b1;
         step();
         bus.sample_en_i = 1'b0;
         check_env_state("gap strobe", strobe_env[s], 3'd1);
         check("gap strobe valid", 32'(bus.valid_o), 32'h1);
         check("gap strobe data", 32'(bus.data_o), 32'(strobe_data[s]));
         held_data  = bus.data_o;
         bus.data_i = 24'h7FFFFF;
         for (int c = 0; c < 3; c++) begin
            step();
            check_env_state("gap hold", strobe_env[s], 3'd1);
            check("gap hold valid", 32'(bus.valid_o), 32'h0);
            check("gap hold data", 32'(bus.data_o), 32'(held_data));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/envelope_adsr.md
# envelope_adsr

ADSR amplitude envelope stage placed directly downstream of the waveform select mux in the keypad synth. Consumes the selected 24-bit signed oscillator sample plus a key-gate, runs an attack/decay/sustain/release state machine at the sample rate, and emits the sample scaled by the current envelope level. Its registered output replaces the raw mux output as the synth's audio output.

## Interface

Parameters:
- width_p, 24, sample width (signed two's complement)
- env_width_p, 16, envelope level width (unsigned fraction, full scale = all ones)

Ports:
- clk_i  in  1  system clock (48 kHz sample clock in the top)
- reset_ni  in  1  asynchronous, active-low reset
- sample_en_i  in  1  one-cycle sample strobe; all state/level updates and output captures occur only when high (tie to 1 in the 48 kHz top)
- gate_i  in  1  key held (1) / released (0)
- attack_rate_i  in  env_width_p  level increment per strobe in ATTACK; 0 = instantaneous
- decay_rate_i  in  env_width_p  decrement per strobe in DECAY; 0 = instantaneous
- sustain_level_i  in  env_width_p  sustain level, sampled live
- release_rate_i  in  env_width_p  decrement per strobe in RELEASE; 0 = instantaneous
- data_i  in  width_p  signed input sample
- data_o  out  width_p  signed enveloped sample
- valid_o  out  1  one-cycle pulse, data_o updated
- env_o  out  env_width_p  current envelope level
- state_o  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
- busy_o  out  1  state_o != IDLE

## Operation

- Registers: state, env level (unsigned), data_o, valid_o. Nothing changes on cycles with sample_en_i low except valid_o dropping to 0.
- Per strobe, gate-driven transitions take priority; a strobe that changes state due to gate leaves env unchanged.
  - IDLE: env held 0. gate_i=1 -> ATTACK.
  - ATTACK: gate_i=0 -> RELEASE. Else env+attack_rate computed at env_width_p+1 bits; if sum >= full scale or rate=0: env=full scale, -> DECAY; else env=sum.
  - DECAY: gate_i=0 -> RELEASE. Else if env-decay_rate <= sustain_level_i (signed compare, no underflow) or rate=0: env=sustain_level_i, -> SUSTAIN; else env-=decay_rate.
  - SUSTAIN: gate_i=0 -> RELEASE. Else env=sustain_level_i (tracks input changes).
  - RELEASE: gate_i=1 -> ATTACK (retrigger from current env, no reset to 0). Else if env <= release_rate or rate=0: env=0, -> IDLE; else env-=release_rate.
- sustain_level_i = full scale: DECAY exits on first strobe with env = full scale.
- Scaling: product = data_i (signed width_p) * {1'b0, env} (signed env_width_p+1), full width_p+env_width_p+1 bits; data_o = product >>> env_width_p (arithmetic, floor), truncated to width_p. Cannot overflow; full scale yields data slightly below input magnitude.
- Scaling uses the env value held before that strobe's update.

## Timing

- Reset (reset_ni low, async): state=IDLE, env_o=0, data_o=0, valid_o=0, busy_o=0, state_o=0; takes effect immediately mid-operation; release synchronous to next edge usage.
- Latency: data_o and valid_o update on the clock edge ending a sample_en_i cycle (1 cycle). valid_o high exactly one cycle per strobe.
- env_o/state_o update on the same edge as data_o.
- Back-to-back strobes (sample_en_i held 1) update every cycle.
- No ready/backpressure; the sample must be valid on every strobe cycle.

## Test plan

- Reset: drive activity, assert reset_ni=0 mid-ATTACK -> data_o=0, env_o=0, state_o=0, valid_o=0 immediately, without waiting for a clock edge.
- Attack: attack_rate=0x1000, gate=1 from IDLE, sample_en=1 -> first strobe enters ATTACK (env 0); following 15 strobes reach env 0xF000; next strobe env=0xFFFF, state DECAY.
- Decay/sustain: decay_rate=0x2000, sustain=0x8000 from 0xFFFF -> 0xDFFF, 0xBFFF, 0x9FFF, then 0x8000 and SUSTAIN; change sustain to 0x6000 -> env_o=0x6000 next strobe.
- Release/retrigger: release_rate=0x4000 at env 0x8000, gate=0 -> RELEASE (env 0x8000), 0x4000, 0 and IDLE; separate run: gate=1 at env 0x4000 in RELEASE -> ATTACK from 0x4000.
- Scaling: env=0xFFFF, data_i=0x7FFFFF -> data_o=0x7FFF7F; data_i=0x800000 -> 0x800080; env=0x8000, data_i=-3 -> data_o=-2 (floor); env=0 -> data_o=0.
- Strobe gating: sample_en_i pulsed every 4th cycle -> env/state change only on strobes, valid_o one cycle per strobe, data_o stable between strobes.
